// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller.
// State encoding, ALU control codes, opcode and DP command fields.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] OP_DP   = 2'b00;
  localparam logic [1:0] OP_MEM  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_NONE = 2'b11;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_BIC = 4'b1110;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_ORR = 3'b101;
  localparam logic [2:0] ALU_EOR = 3'b110;
  localparam logic [2:0] ALU_BIC = 3'b111;

endpackage

// File: rtl/mc_condcheck.sv
// ARM condition evaluation from the registered {N,Z,C,V} flags.
// Code 1111 is treated as never-execute.
module mc_condcheck (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);

  logic n, z, c, v, ge;

  assign {n, z, c, v} = flags;
  assign ge = (n == v);

  always_comb begin
    condex = 1'b0;
    unique case (cond)
      4'h0: condex = z;
      4'h1: condex = ~z;
      4'h2: condex = c;
      4'h3: condex = ~c;
      4'h4: condex = n;
      4'h5: condex = ~n;
      4'h6: condex = v;
      4'h7: condex = ~v;
      4'h8: condex = c & ~z;
      4'h9: condex = ~c | z;
      4'hA: condex = ge;
      4'hB: condex = ~ge;
      4'hC: condex = ~z & ge;
      4'hD: condex = z | ~ge;
      4'hE: condex = 1'b1;
      4'hF: condex = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle controller: main FSM, ALU decode and flag register
// for a shared instruction/data memory datapath.
module mc_controller
  import mc_pkg::*;
#(
  parameter int BYTE_EN   = 1,
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 ByteAcc,
  output logic [3:0]           State
);

  state_t     st, nxt;
  logic [3:0] flags;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [2:0] alu;
  logic       condex, aluop, legal, cmp, arith;
  logic       wok, flag_ld, byte_sel;
  logic       pcw, rw, mw;
  logic       unused_rn;

  assign {cond, op, funct} = Instr[19:8];
  assign rd        = Instr[3:0];
  assign unused_rn = ^Instr[7:4];

  mc_condcheck u_cc (
    .cond   (cond),
    .flags  (flags),
    .condex (condex)
  );

  always_comb begin
    alu   = ALU_ADD;
    legal = 1'b1;
    cmp   = 1'b0;
    arith = 1'b0;
    unique case (funct[4:1])
      CMD_ADD: arith = 1'b1;
      CMD_SUB: begin alu = ALU_SUB; arith = 1'b1; end
      CMD_AND: alu = ALU_AND;
      CMD_ORR: alu = ALU_ORR;
      CMD_EOR: alu = ALU_EOR;
      CMD_BIC: alu = ALU_BIC;
      CMD_CMP: begin alu = ALU_SUB; arith = 1'b1; cmp = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  assign aluop    = (st == S_EXECR) || (st == S_EXECI);
  assign wok      = legal & ~cmp;
  assign flag_ld  = aluop & condex & legal & (funct[0] | cmp);
  assign byte_sel = (BYTE_EN != 0) & funct[2];

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= S_FETCH;
      flags <= 4'b0000;
    end else begin
      st <= nxt;
      if (flag_ld) begin
        flags[3:2] <= ALUFlags[3:2];
        if (arith) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    nxt       = st;
    pcw       = 1'b0;
    rw        = 1'b0;
    mw        = 1'b0;
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ByteAcc   = 1'b0;
    unique case (st)
      S_FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        pcw       = MemReady;
        if (MemReady) nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        unique case (op)
          OP_MEM:  nxt = S_MEMADR;
          OP_BR:   nxt = S_BRANCH;
          OP_DP:   nxt = funct[5] ? S_EXECI : S_EXECR;
          OP_NONE: nxt = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
        nxt     = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc  = 1'b1;
        ByteAcc = byte_sel;
        if (MemReady) nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        rw        = condex;
        nxt       = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc  = 1'b1;
        ByteAcc = byte_sel;
        mw      = condex;
        if (MemReady) nxt = S_FETCH;
      end
      S_EXECR: nxt = S_ALUWB;
      S_EXECI: begin
        ALUSrcB = 2'b01;
        nxt     = S_ALUWB;
      end
      S_ALUWB: begin
        // A write to R15 redirects the PC instead of the register file
        if (rd == 4'hF) pcw = condex & wok;
        else            rw  = condex & wok;
        nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        pcw       = condex;
        nxt       = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  assign PCWrite    = pcw & ~reset;
  assign RegWrite   = rw & ~reset;
  assign MemWrite   = mw & ~reset;
  assign ALUControl = aluop ? ALUCTRL_W'(alu) : '0;
  assign ImmSrc     = (op == OP_NONE) ? 2'b00 : op;
  assign RegSrc     = {op == OP_MEM, op == OP_BR};
  assign State      = st;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-instruction cycle plans from a behavioural
// model, checked every cycle, plus literal checks on recorded traces.
module tb_mc_controller;
  import mc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        MemReady;

  logic       PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ByteAcc;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;
  logic [3:0] State;

  logic       PCWrite0, IRWrite0, RegWrite0, MemWrite0, AdrSrc0, ByteAcc0;
  logic [1:0] ResultSrc0, ALUSrcA0, ALUSrcB0, ImmSrc0, RegSrc0;
  logic [2:0] ALUControl0;
  logic [3:0] State0;

  always #5 clk = ~clk;

  mc_controller #(.BYTE_EN(1), .ALUCTRL_W(3)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .ByteAcc(ByteAcc), .State(State)
  );

  mc_controller #(.BYTE_EN(0), .ALUCTRL_W(3)) dut0 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .MemReady(MemReady), .PCWrite(PCWrite0), .IRWrite(IRWrite0),
    .RegWrite(RegWrite0), .MemWrite(MemWrite0), .AdrSrc(AdrSrc0),
    .ResultSrc(ResultSrc0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0),
    .ImmSrc(ImmSrc0), .RegSrc(RegSrc0), .ALUControl(ALUControl0),
    .ByteAcc(ByteAcc0), .State(State0)
  );

  typedef struct {
    logic [3:0] st;
    logic       pcw, irw, rw, mw, adr, ba;
    logic [1:0] res, sa, sb, imm, rsrc;
    logic [2:0] alu;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic [3:0] mflags = 4'b0000;

  logic [3:0] lg_st[$];
  logic       lg_rw[$], lg_pcw[$], lg_mw[$], lg_ba[$], lg_ba0[$];
  logic [2:0] lg_alu[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Odd condition codes are the negation of the even code below them;
  // this makes 1111 the negation of AL.
  function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? !r : r;
  endfunction

  // {valid, alucontrol}
  function automatic logic [3:0] m_alu(input logic [3:0] cmd);
    case (cmd)
      4'b0100: return 4'b1000;
      4'b0010: return 4'b1001;
      4'b0000: return 4'b1100;
      4'b1100: return 4'b1101;
      4'b0001: return 4'b1110;
      4'b1110: return 4'b1111;
      4'b1010: return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic exp_t blank(input logic [19:0] ins, input logic [3:0] s);
    exp_t e;
    e.st = s; e.pcw = 0; e.irw = 0; e.rw = 0; e.mw = 0; e.adr = 0;
    e.ba = 0; e.res = 0; e.sa = 0; e.sb = 0; e.alu = 0;
    e.imm  = (ins[15:14] == 2'b11) ? 2'b00 : ins[15:14];
    e.rsrc = {ins[15:14] == 2'b01, ins[15:14] == 2'b10};
    return e;
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("State", State, e.st);
      chk("PCWrite", PCWrite, e.pcw);
      chk("IRWrite", IRWrite, e.irw);
      chk("RegWrite", RegWrite, e.rw);
      chk("MemWrite", MemWrite, e.mw);
      chk("AdrSrc", AdrSrc, e.adr);
      chk("ResultSrc", ResultSrc, e.res);
      chk("ALUSrcA", ALUSrcA, e.sa);
      chk("ALUSrcB", ALUSrcB, e.sb);
      chk("ALUControl", ALUControl, e.alu);
      chk("ImmSrc", ImmSrc, e.imm);
      chk("RegSrc", RegSrc, e.rsrc);
      chk("ByteAcc", ByteAcc, e.ba);
      chk("ByteAcc_nobyte", ByteAcc0, 0);
      chk("State_nobyte", State0, e.st);
      lg_st.push_back(State);
      lg_rw.push_back(RegWrite);
      lg_pcw.push_back(PCWrite);
      lg_mw.push_back(MemWrite);
      lg_ba.push_back(ByteAcc);
      lg_ba0.push_back(ByteAcc0);
      lg_alu.push_back(ALUControl);
    end
  end

  task automatic cyc(input exp_t e, input logic mr);
    MemReady = mr;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [19:0] ins, input int fst, input int mst,
                     input logic [3:0] af, input bit rst_mem);
    exp_t e;
    logic [3:0] cond, rd, v;
    logic [1:0] op;
    logic [5:0] fn;
    logic ce, cmp, arith, wr;
    lg_st.delete(); lg_rw.delete(); lg_pcw.delete(); lg_mw.delete();
    lg_ba.delete(); lg_ba0.delete(); lg_alu.delete();
    Instr = ins;
    ALUFlags = af;
    {cond, op, fn} = ins[19:8];
    rd = ins[3:0];
    e = blank(ins, S_FETCH);
    e.sa = 1; e.sb = 2; e.res = 2;
    for (int i = 0; i < fst; i++) cyc(e, 1'b0);
    e.pcw = 1; e.irw = 1;
    cyc(e, 1'b1);
    e = blank(ins, S_DECODE);
    e.sa = 1; e.sb = 2; e.res = 2;
    cyc(e, 1'b1);
    ce = m_cond(cond, mflags);
    if (op == 2'b01) begin
      e = blank(ins, S_MEMADR);
      e.sb = 1;
      cyc(e, 1'b1);
      if (fn[0]) begin
        e = blank(ins, S_MEMRD);
        e.adr = 1; e.ba = fn[2];
        for (int i = 0; i < mst; i++) cyc(e, 1'b0);
        cyc(e, 1'b1);
        e = blank(ins, S_MEMWB);
        e.res = 1; e.rw = ce;
        cyc(e, 1'b1);
      end else begin
        e = blank(ins, S_MEMWR);
        e.adr = 1; e.ba = fn[2]; e.mw = ce;
        for (int i = 0; i < mst; i++) cyc(e, 1'b0);
        if (rst_mem) begin
          reset = 1'b1;
          e.mw = 0;
          cyc(e, 1'b0);
          reset = 1'b0;
          mflags = 4'b0000;
        end else begin
          cyc(e, 1'b1);
        end
      end
    end else if (op == 2'b00) begin
      v = m_alu(fn[4:1]);
      cmp = (fn[4:1] == 4'b1010);
      arith = v[3] && (v[2:1] == 2'b00);
      e = blank(ins, fn[5] ? S_EXECI : S_EXECR);
      e.sb = fn[5] ? 2'd1 : 2'd0;
      e.alu = v[2:0];
      cyc(e, 1'b1);
      if (ce && v[3] && (fn[0] || cmp)) begin
        mflags[3:2] = af[3:2];
        if (arith) mflags[1:0] = af[1:0];
      end
      wr = m_cond(cond, mflags) && v[3] && !cmp;
      e = blank(ins, S_ALUWB);
      if (rd == 4'hF) e.pcw = wr;
      else e.rw = wr;
      cyc(e, 1'b1);
    end else if (op == 2'b10) begin
      e = blank(ins, S_BRANCH);
      e.sb = 1; e.res = 2; e.pcw = ce;
      cyc(e, 1'b1);
    end
  endtask

  task automatic branch_sweep();
    for (int c = 0; c < 16; c++) run({c[3:0], 16'hA000}, 0, 0, 4'h0, 0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    MemReady = 1'b1;
    Instr = 20'h0;
    ALUFlags = 4'h0;
    @(posedge clk);
    #1;
    e = blank(20'h0, S_FETCH);
    e.sa = 1; e.sb = 2; e.res = 2; e.irw = 1;
    cyc(e, 1'b1);
    reset = 1'b0;

    run(20'hE2821, 0, 0, 4'h0, 0);
    chk("add_len", lg_st.size(), 4);
    chk("add_st2", lg_st[2], S_EXECI);
    chk("add_st3", lg_st[3], S_ALUWB);
    chk("add_rw3", lg_rw[3], 1);
    chk("add_rw2", lg_rw[2], 0);
    chk("add_alu", lg_alu[2], 3'b000);

    run(20'hE5910, 0, 3, 4'h0, 0);
    chk("ldr_len", lg_st.size(), 8);
    chk("ldr_st5", lg_st[5], S_MEMRD);
    chk("ldr_st7", lg_st[7], S_MEMWB);
    chk("ldr_rw6", lg_rw[6], 0);
    chk("ldr_rw7", lg_rw[7], 1);

    run(20'hE0500, 0, 0, 4'b0100, 0);
    chk("subs_alu", lg_alu[2], 3'b001);
    run(20'h1A000, 0, 0, 4'h0, 0);
    chk("bne_st2", lg_st[2], S_BRANCH);
    chk("bne_pcw", lg_pcw[2], 0);
    run(20'h0A000, 0, 0, 4'h0, 0);
    chk("beq_pcw", lg_pcw[2], 1);

    run(20'hE5C12, 0, 2, 4'h0, 0);
    chk("strb_st", lg_st[3], S_MEMWR);
    chk("strb_ba", lg_ba[3], 1);
    chk("strb_mw", lg_mw[4], 1);
    chk("strb_ba0", lg_ba0[3], 0);

    run(20'hE280F, 0, 0, 4'h0, 0);
    chk("pc_pcw", lg_pcw[3], 1);
    chk("pc_rw", lg_rw[3], 0);

    run(20'hE0200, 0, 0, 4'h0, 0);
    chk("eor_alu", lg_alu[2], 3'b110);
    run(20'hE1C00, 0, 0, 4'h0, 0);
    chk("bic_alu", lg_alu[2], 3'b111);
    run(20'hE0000, 1, 0, 4'h0, 0);
    run(20'hE0F00, 0, 0, 4'hF, 0);
    chk("bad_alu", lg_alu[2], 3'b000);
    chk("bad_rw", lg_rw[3], 0);
    run(20'hEC000, 2, 0, 4'h0, 0);
    chk("op3_len", lg_st.size(), 4);
    run(20'hF2821, 0, 0, 4'h0, 0);
    chk("nv_rw", lg_rw[3], 0);

    run(20'hE1900, 0, 0, 4'b1011, 0);
    branch_sweep();
    run(20'hE0900, 0, 0, 4'b0011, 0);
    branch_sweep();
    run(20'hE1510, 0, 0, 4'b0110, 0);
    chk("cmp_rw", lg_rw[3], 0);
    branch_sweep();
    run(20'hE0900, 0, 0, 4'b1001, 0);
    branch_sweep();

    run(20'hE0500, 0, 0, 4'b0100, 0);
    run(20'hE5810, 0, 2, 4'h0, 1);
    chk("rst_mw", lg_mw[5], 0);
    chk("rst_st", lg_st[5], S_MEMWR);
    run(20'h02821, 0, 0, 4'h0, 0);
    chk("rst_st0", lg_st[0], S_FETCH);
    chk("rst_flags", lg_rw[3], 0);
    run(20'h12821, 0, 0, 4'h0, 0);
    chk("rst_ne", lg_rw[3], 1);
    branch_sweep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter BYTE_EN, default 1: enables LDRB/STRB decode (Funct[2]=B); when 0, B is ignored and all transfers are word transfers.
REQ-002 Parameter ALUCTRL_W, default 3: ALUControl width.
REQ-003 Ports, in order: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-004 Instr in 20: instruction register bits [31:12] (Cond, Op, Funct, Rn, Rd).
REQ-005 ALUFlags in 4: {N,Z,C,V} from the ALU this cycle.
REQ-006 MemReady in 1: shared instruction/data memory has completed the current access.
REQ-007 PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc out 1 each.
REQ-008 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc out 2 each.
REQ-009 ALUControl out ALUCTRL_W.
REQ-010 ByteAcc out 1: current memory access is a byte access.
REQ-011 State out 4: FSM state, for debug.

Function
REQ-012 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH; encoding is held in the package.
REQ-013 FETCH: AdrSrc=0, ALUSrcA=01 (PC), ALUSrcB=10 (const 4), ResultSrc=10. IRWrite=PCWrite=MemReady. Stay in FETCH while MemReady=0, else go to DECODE.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state by Op: 01 -> MEMADR; 10 -> BRANCH; 00 with Funct[5]=1 -> EXECI; 00 with Funct[5]=0 -> EXECR; Op=11 -> FETCH with no side effects.
REQ-015 MEMADR: ALUSrcA=00, ALUSrcB=01. L=1 -> MEMRD, L=0 -> MEMWR.
REQ-016 MEMRD: AdrSrc=1. Hold while MemReady=0, else go to MEMWB.
REQ-017 MEMWB: ResultSrc=01, RegWrite=CondEx, then go to FETCH.
REQ-018 MEMWR: AdrSrc=1, MemWrite=CondEx. Hold while MemReady=0, with MemWrite held stable; then go to FETCH.
REQ-019 EXECR: ALUSrcA=00, ALUSrcB=00. EXECI: ALUSrcB=01. Both ALUOp=1, then go to ALUWB.
REQ-020 ALUWB: ResultSrc=00, RegWrite=CondEx, then go to FETCH. If Rd=15, PCWrite=CondEx and RegWrite=0.
REQ-021 BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, PCWrite=CondEx, then go to FETCH.
REQ-022 ALU decode when ALUOp=1, on Funct[4:1]: 0100 ADD=000, 0010 SUB=001, 0000 AND=100, 1100 ORR=101, 0001 EOR=110, 1110 BIC=111, 1010 CMP=001 with RegWrite suppressed. Any other encoding gives ALUControl=000 and suppresses writes. When ALUOp=0, ALUControl=000.
REQ-023 Flag register: 4 bits {N,Z,C,V}, loaded at the end of EXECR/EXECI when S=1 and CondEx=1. N,Z always load; C,V load only for ADD/SUB/CMP. CMP loads flags regardless of S.
REQ-024 CondEx: combinational from Cond and the registered flags, per ARM EQ..AL. Cond=1111 gives CondEx=0.
REQ-025 ImmSrc from Op: 00 -> 00, 01 -> 01, 10 -> 10. RegSrc = {Op==01, Op==10}.
REQ-026 ByteAcc = BYTE_EN & Funct[2] in MEMRD and MEMWR, else 0.
REQ-027 Outputs not listed for a state are 0. All outputs are combinational from State, Instr, flags and MemReady.

Reset
REQ-028 reset=1 at a clk edge sets State=FETCH and flags=0000. This takes priority over MemReady and any in-progress stall.
REQ-029 While reset=1, RegWrite, MemWrite and PCWrite are 0.

Structure
REQ-030 Package mc_pkg holds the state enum, the ALUControl constants and the Op codes.
REQ-031 Sub-module mc_condcheck evaluates CondEx from Cond and flags, combinationally.
REQ-032 The flag register and state register are the only storage.

Verification
REQ-033 ADD R1,R2,#5 (E2821005), MemReady=1 -> FETCH, DECODE, EXECI, ALUWB; RegWrite=1 in cycle 4; 4-cycle instruction.
REQ-034 LDR with MemReady low 3 cycles in MEMRD -> MEMRD held 3 cycles; RegWrite=1 only in MEMWB; 8 cycles total.
REQ-035 SUBS giving 0, then BNE -> Z=1 stored; BRANCH has PCWrite=0; next FETCH occurs.
REQ-036 STRB (E5C12004), BYTE_EN=1 -> ByteAcc=1 and MemWrite=1 in MEMWR; with BYTE_EN=0, ByteAcc=0.
REQ-037 reset asserted mid-MEMWR stall -> next state FETCH; MemWrite=0 while reset=1; flags=0000.
REQ-038 MOV PC-style ADD R15,R0,#0x40 -> ALUWB has PCWrite=1 and RegWrite=0.
